// File: rtl/adder_share_arb.sv
// Round-robin arbiter sharing one 3-bit ripple-carry adder among NREQ requesters.
// Define ADDER_ARB_STATS_EN to add the op_count/drop_count statistics outputs.
module adder_share_arb #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned ID_W     = $clog2(NREQ),
    parameter int unsigned MAX_WAIT = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [3*NREQ-1:0] a_in,
    input  logic [3*NREQ-1:0] b_in,
    input  logic [NREQ-1:0]   cin_in,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic              res_valid,
    output logic [2:0]        res_sum,
    output logic              res_cout,
    output logic [ID_W-1:0]   res_id,
    input  logic              res_ready,
`ifdef ADDER_ARB_STATS_EN
    output logic [15:0]       op_count,
    output logic [7:0]        drop_count,
`endif
    output logic              drop
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e          state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [2:0]      opa_q, opa_d, opb_q, opb_d;
    logic            opc_q, opc_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            res_valid_q, res_valid_d;
    logic [2:0]      res_sum_q, res_sum_d;
    logic            res_cout_q, res_cout_d;
    logic [ID_W-1:0] res_id_q, res_id_d;
    logic            drop_q, drop_d;
    logic [9:0]      wait_q, wait_d;

    logic [2:0] a_arr [NREQ];
    logic [2:0] b_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign a_arr[g] = a_in[3*g+2 -: 3];
        assign b_arr[g] = b_in[3*g+2 -: 3];
    end

    // Rotate requests so bit k belongs to requester (ptr+1+k) mod NREQ.
    logic [2*NREQ-1:0] req_rot;
    logic              win_found;
    int unsigned       win_int;
    logic [ID_W-1:0]   win_idx;

    always_comb begin
        req_rot   = {req, req} >> (32'(ptr_q) + 32'd1);
        win_found = 1'b0;
        win_int   = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!win_found && req_rot[k]) begin
                win_found = 1'b1;
                win_int   = (32'(ptr_q) + 32'd1 + k) % NREQ;
            end
        end
        win_idx = win_int[ID_W-1:0];
    end

    // Shared 3-bit ripple-carry adder on the captured operands.
    logic [2:0] add_sum;
    logic       carry;

    always_comb begin
        add_sum = '0;
        carry   = opc_q;
        for (int i = 0; i < 3; i++) begin
            add_sum[i] = opa_q[i] ^ opb_q[i] ^ carry;
            carry      = (opa_q[i] & opb_q[i]) | (carry & (opa_q[i] ^ opb_q[i]));
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        opc_d       = opc_q;
        gnt_d       = '0;
        drop_d      = 1'b0;
        res_valid_d = res_valid_q;
        res_sum_d   = res_sum_q;
        res_cout_d  = res_cout_q;
        res_id_d    = res_id_q;
        wait_d      = wait_q;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    ptr_d   = win_idx;
                    opa_d   = a_arr[win_idx];
                    opb_d   = b_arr[win_idx];
                    opc_d   = cin_in[win_idx];
                    gnt_d   = NREQ'(1) << win_idx;
                    state_d = StExec;
                end
            end
            StExec: begin
                res_sum_d   = add_sum;
                res_cout_d  = carry;
                res_id_d    = ptr_q;
                res_valid_d = 1'b1;
                wait_d      = '0;
                state_d     = StResp;
            end
            StResp: begin
                // Acceptance wins over the watchdog in the same cycle.
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = StIdle;
                end else if (wait_q == 10'(MAX_WAIT - 1)) begin
                    res_valid_d = 1'b0;
                    drop_d      = 1'b1;
                    state_d     = StIdle;
                end else begin
                    wait_d = wait_q + 10'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            ptr_q       <= ID_W'(NREQ - 1);
            opa_q       <= '0;
            opb_q       <= '0;
            opc_q       <= 1'b0;
            gnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_cout_q  <= 1'b0;
            res_id_q    <= '0;
            drop_q      <= 1'b0;
            wait_q      <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            opc_q       <= opc_d;
            gnt_q       <= gnt_d;
            res_valid_q <= res_valid_d;
            res_sum_q   <= res_sum_d;
            res_cout_q  <= res_cout_d;
            res_id_q    <= res_id_d;
            drop_q      <= drop_d;
            wait_q      <= wait_d;
        end
    end

    assign gnt       = gnt_q;
    assign busy      = (state_q != StIdle);
    assign res_valid = res_valid_q;
    assign res_sum   = res_sum_q;
    assign res_cout  = res_cout_q;
    assign res_id    = res_id_q;
    assign drop      = drop_q;

`ifdef ADDER_ARB_STATS_EN
    logic [15:0] op_count_q;
    logic [7:0]  drop_count_q;
    logic        handshake;

    assign handshake = (state_q == StResp) && res_valid_q && res_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            op_count_q   <= '0;
            drop_count_q <= '0;
        end else begin
            if (handshake && op_count_q != 16'hFFFF) begin
                op_count_q <= op_count_q + 16'd1;
            end
            if (drop_d && drop_count_q != 8'hFF) begin
                drop_count_q <= drop_count_q + 8'd1;
            end
        end
    end

    assign op_count   = op_count_q;
    assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_adder_share_arb.sv
// Randomized self-checking bench for adder_share_arb against a transaction-level model.
module tb_adder_share_arb;

    localparam int NREQ     = 4;
    localparam int MAX_WAIT = 6;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [11:0] a_in;
    logic [11:0] b_in;
    logic [3:0]  cin_in;
    logic [3:0]  gnt;
    logic        busy;
    logic        res_valid;
    logic [2:0]  res_sum;
    logic        res_cout;
    logic [1:0]  res_id;
    logic        res_ready;
    logic        drop;
`ifdef ADDER_ARB_STATS_EN
    logic [15:0] op_count;
    logic [7:0]  drop_count;
`endif

    adder_share_arb #(
        .NREQ    (NREQ),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .a_in     (a_in),
        .b_in     (b_in),
        .cin_in   (cin_in),
        .gnt      (gnt),
        .busy     (busy),
        .res_valid(res_valid),
        .res_sum  (res_sum),
        .res_cout (res_cout),
        .res_id   (res_id),
        .res_ready(res_ready),
`ifdef ADDER_ARB_STATS_EN
        .op_count  (op_count),
        .drop_count(drop_count),
`endif
        .drop     (drop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;

    // Model state: last granted requester, per-requester operands, event counts.
    int m_ptr = NREQ - 1;
    int m_ops = 0;
    int m_drops = 0;
    int a_v [NREQ];
    int b_v [NREQ];
    int c_v [NREQ];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic randomize_ops();
        for (int i = 0; i < NREQ; i++) begin
            a_v[i] = int'($urandom_range(0, 7));
            b_v[i] = int'($urandom_range(0, 7));
            c_v[i] = int'($urandom_range(0, 1));
        end
    endtask

    // One operation from IDLE; delay >= MAX_WAIT means the consumer never accepts.
    task automatic run_op(input logic [3:0] mask, input int delay);
        int w;
        int total;
        int hi;
        w = -1;
        for (int off = 1; off <= NREQ; off++) begin
            if (w < 0 && mask[(m_ptr + off) % NREQ]) w = (m_ptr + off) % NREQ;
        end
        total = a_v[w] + b_v[w] + c_v[w];
        for (int i = 0; i < NREQ; i++) begin
            a_in[3*i +: 3] = 3'(a_v[i]);
            b_in[3*i +: 3] = 3'(b_v[i]);
            cin_in[i]      = c_v[i][0];
        end
        req = mask;
        res_ready = 1'b0;
        @(posedge clk); #1;
        check("gnt", 32'(gnt), 32'(1) << w);
        check("busy_gnt", 32'(busy), 1);
        check("valid_early", 32'(res_valid), 0);
        m_ptr = w;
        req = '0;
        @(posedge clk); #1;
        check("valid", 32'(res_valid), 1);
        check("sum_cout", {28'd0, res_cout, res_sum}, 32'(total));
        check("id", 32'(res_id), 32'(w));
        check("gnt_pulse", 32'(gnt), 0);
        if (delay < MAX_WAIT) begin
            res_ready = (delay == 0);
            for (int k = 0; k < delay; k++) begin
                @(posedge clk); #1;
                check("bp_valid", 32'(res_valid), 1);
                check("bp_data", {26'd0, res_id, res_cout, res_sum}, {26'd0, 2'(w), 4'(total)});
                if (k == delay - 1) res_ready = 1'b1;
            end
            @(posedge clk); #1;
            check("hs_valid", 32'(res_valid), 0);
            check("hs_drop", 32'(drop), 0);
            check("hs_busy", 32'(busy), 0);
            res_ready = 1'b0;
            m_ops++;
        end else begin
            hi = 1;
            for (int k = 0; k < 4 * MAX_WAIT; k++) begin
                @(posedge clk); #1;
                if (!res_valid) break;
                hi++;
            end
            check("wd_len", 32'(hi), 32'(MAX_WAIT));
            check("wd_drop", 32'(drop), 1);
            check("wd_busy", 32'(busy), 0);
            @(posedge clk); #1;
            check("wd_drop_pulse", 32'(drop), 0);
            m_drops++;
        end
    endtask

    initial begin
        rst = 1'b0;
        req = '0;
        a_in = '0;
        b_in = '0;
        cin_in = '0;
        res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_outs", {25'd0, gnt, busy, res_valid, drop},  0);
        check("rst_res", {26'd0, res_id, res_cout, res_sum}, 0);
        rst = 1'b1;

        // Single op on requester 0: 3+2+1 = 6.
        a_v = '{3, 0, 0, 0};
        b_v = '{2, 0, 0, 0};
        c_v = '{1, 0, 0, 0};
        run_op(4'b0001, 0);
        check("single_sum", {28'd0, res_cout, res_sum}, 6);

        // Overflow on requester 2.
        a_v[2] = 7; b_v[2] = 7; c_v[2] = 1;
        run_op(4'b0100, 0);
        check("ovf_15", {28'd0, res_cout, res_sum}, 15);
        a_v[2] = 7; b_v[2] = 0; c_v[2] = 1;
        run_op(4'b0100, 0);
        check("ovf_8", {28'd0, res_cout, res_sum}, 8);

        // Continuous requests rotate 3,0,1,2,...
        for (int i = 0; i < 8; i++) begin
            randomize_ops();
            run_op(4'b1111, 0);
            check("rr_order", 32'(res_id), 32'((3 + i) % NREQ));
        end

        // Backpressure up to the last watchdog cycle: acceptance wins.
        randomize_ops();
        run_op(4'b1010, MAX_WAIT - 1);

        // Watchdog, then the next request is served.
        randomize_ops();
        run_op(4'b0001, MAX_WAIT);
        randomize_ops();
        run_op(4'b0010, 0);
`ifdef ADDER_ARB_STATS_EN
        check("drop_count", 32'(drop_count), 32'(m_drops));
`endif

        for (int i = 0; i < 40; i++) begin
            randomize_ops();
            run_op(4'($urandom_range(1, 15)), int'($urandom_range(0, MAX_WAIT)));
        end
`ifdef ADDER_ARB_STATS_EN
        check("op_count", 32'(op_count), 32'(m_ops));
        check("drop_count_end", 32'(drop_count), 32'(m_drops));
`endif

        // Reset while a result is pending.
        req = 4'b0001;
        @(posedge clk); #1;
        req = '0;
        @(posedge clk); #1;
        check("mr_pending", 32'(res_valid), 1);
        rst = 1'b0;
        @(posedge clk); #1;
        check("mr_outs", {29'd0, busy, res_valid, drop}, 0);
        rst = 1'b1;
        m_ptr = NREQ - 1;
        m_ops = 0;
        m_drops = 0;
        randomize_ops();
        run_op(4'b0110, 0);
        check("mr_first", 32'(res_id), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
